// File: rtl/pixel_lane_writer.sv
// Frame-aware pixel unpacker: spreads each LANES-pixel word across LANES line-buffer RAMs.
// Optional ring addressing via PLW_RING_EN; without it, words past DEPTH are dropped and flag ovf.
module pixel_lane_writer #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DIM_W  = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [DIM_W-1:0]         i_rows,
  input  logic [DIM_W-1:0]         i_cols,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [LANES*PIX_W-1:0]   i_in_data,
  output logic [LANES-1:0]         o_wr_en,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [LANES*PIX_W-1:0]   o_wr_data,
  output logic [2*DIM_W-1:0]       o_pixel_count,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_dim_err,
  output logic                     o_ovf
);

  localparam int unsigned PC_W  = 2 * DIM_W;
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned WA_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [PC_W-1:0]          r_total;
  logic [PC_W-1:0]          r_pixel_count;
  logic [WA_W-1:0]          r_waddr;
  logic [LANES-1:0]         r_wr_en;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [LANES*PIX_W-1:0]   r_wr_data;
  logic                     r_in_ready;
  logic                     r_busy;
  logic                     r_frame_done;
  logic                     r_dim_err;
  logic                     r_ovf;

  logic                     w_in_ready_nxt;
  logic                     w_busy_nxt;
  logic                     w_frame_done_nxt;
  logic [PC_W-1:0]          w_remaining;
  logic                     w_accept;
  logic                     w_start_ok;
  logic                     w_start_bad;
  logic                     w_last;
  logic [CNT_W-1:0]         w_take;
  logic [LANES-1:0]         w_mask;
  logic                     w_oob;
  logic [WA_W-1:0]          w_waddr_nxt;

  assign w_remaining = r_total - r_pixel_count;
  assign w_accept    = i_in_valid && r_in_ready;
  assign w_start_ok  = i_start && (r_state == ST_IDLE) && (i_rows != '0) && (i_cols != '0);
  assign w_start_bad = i_start && (r_state == ST_IDLE) && ((i_rows == '0) || (i_cols == '0));
  assign w_last      = w_accept && (w_remaining <= PC_W'(LANES));
  assign w_take      = (w_remaining >= PC_W'(LANES)) ? CNT_W'(LANES) : CNT_W'(w_remaining);

  // Lanes past the end of the frame stay silent on the final, partial word.
  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_mask[k] = (CNT_W'(k) < w_take);
    end
  end

`ifdef PLW_RING_EN
  assign w_oob       = 1'b0;
  assign w_waddr_nxt = (r_waddr == WA_W'(DEPTH - 1)) ? '0 : r_waddr + WA_W'(1);
`else
  // Once a frame has overrun, every later word is out of range as well.
  assign w_oob       = r_ovf || (r_waddr >= WA_W'(DEPTH));
  assign w_waddr_nxt = r_waddr + WA_W'(1);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next_state = ST_RUN;
      ST_RUN:  if (w_last)     w_next_state = ST_DONE;
      ST_DONE:                 w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    w_in_ready_nxt   = 1'b0;
    w_busy_nxt       = 1'b0;
    w_frame_done_nxt = 1'b0;
    case (w_next_state)
      ST_RUN:  begin w_in_ready_nxt = 1'b1; w_busy_nxt = 1'b1; end
      ST_DONE: begin w_busy_nxt = 1'b1; w_frame_done_nxt = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_total       <= '0;
      r_pixel_count <= '0;
      r_waddr       <= '0;
      r_wr_en       <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_dim_err     <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_wr_en      <= '0;
      if (w_start_ok) begin
        r_total       <= PC_W'(i_rows) * PC_W'(i_cols);
        r_pixel_count <= '0;
        r_waddr       <= '0;
        r_ovf         <= 1'b0;
        r_dim_err     <= 1'b0;
      end else if (w_start_bad) begin
        r_dim_err <= 1'b1;
      end
      if (w_accept) begin
        r_wr_data     <= i_in_data;
        r_wr_en       <= w_oob ? '0 : w_mask;
        r_wr_addr     <= ADDR_W'(r_waddr);
        r_waddr       <= w_waddr_nxt;
        r_pixel_count <= r_pixel_count + PC_W'(w_take);
        if (w_oob) r_ovf <= 1'b1;
      end
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_pixel_count = r_pixel_count;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_dim_err     = r_dim_err;
  assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_pixel_lane_writer.sv
// Bench for pixel_lane_writer (DEPTH=4): frame-level reference model checked every cycle,
// plus directed literal expectations. Honours PLW_RING_EN when defined.
module tb_pixel_lane_writer;

  localparam int unsigned L   = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned DEP = 4;
  localparam int unsigned DW  = 16;
`ifdef PLW_RING_EN
  localparam bit RING = 1'b1;
`else
  localparam bit RING = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   rows;
  logic [DW-1:0]   cols;
  logic            in_valid;
  logic            in_ready;
  logic [L*PW-1:0] in_data;
  logic [L-1:0]    wr_en;
  logic [AW-1:0]   wr_addr;
  logic [L*PW-1:0] wr_data;
  logic [2*DW-1:0] pixel_count;
  logic            busy;
  logic            frame_done;
  logic            dim_err;
  logic            ovf;

  int n_checks = 0;
  int n_errors = 0;

  pixel_lane_writer #(
    .PIX_W(PW), .LANES(L), .ADDR_W(AW), .DEPTH(DEP), .DIM_W(DW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_rows(rows), .i_cols(cols),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_pixel_count(pixel_count), .o_busy(busy), .o_frame_done(frame_done),
    .o_dim_err(dim_err), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: 0 idle, 1 receiving, 2 frame-complete cycle.
  bit              m_init = 1'b0;
  int              m_mode;
  longint          m_total;
  longint          m_count;
  int              m_idx;
  int              m_n;
  bit              m_oob;
  logic [L-1:0]    e_en;
  logic [AW-1:0]   e_addr;
  logic [L*PW-1:0] e_data;
  longint          e_pc;
  bit              e_ready, e_busy, e_done, e_dim, e_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_mode = 0; m_total = 0; m_count = 0; m_idx = 0;
      e_en = '0; e_addr = '0; e_data = '0; e_dim = 1'b0; e_ovf = 1'b0;
    end else if (m_init) begin
      e_en = '0;
      case (m_mode)
        0: if (start) begin
          if (rows == 0 || cols == 0) e_dim = 1'b1;
          else begin
            m_total = longint'(rows) * longint'(cols);
            m_count = 0; m_idx = 0; e_ovf = 1'b0; e_dim = 1'b0; m_mode = 1;
          end
        end
        1: if (in_valid) begin
          m_n    = (m_total - m_count >= L) ? L : int'(m_total - m_count);
          m_oob  = !RING && (m_idx >= DEP);
          e_addr = AW'(RING ? (m_idx % DEP) : m_idx);
          e_en   = m_oob ? '0 : L'((1 << m_n) - 1);
          if (m_oob) e_ovf = 1'b1;
          e_data = in_data;
          m_count += m_n;
          m_idx++;
          if (m_count == m_total) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
    e_pc    = m_count;
    e_ready = (m_mode == 1);
    e_busy  = (m_mode != 0);
    e_done  = (m_mode == 2);
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_wr_en", wr_en, e_en);
      chk("m_wr_addr", wr_addr, e_addr);
      chk("m_wr_data", wr_data, e_data);
      chk("m_pixel_count", pixel_count, e_pc);
      chk("m_in_ready", in_ready, e_ready);
      chk("m_busy", busy, e_busy);
      chk("m_frame_done", frame_done, e_done);
      chk("m_dim_err", dim_err, e_dim);
      chk("m_ovf", ovf, e_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int r, input int c);
    rows = DW'(r); cols = DW'(c); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rows = '0; cols = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    chk("rst_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pc", pixel_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // 2x4 frame: two full words
    pulse_start(2, 4);
    chk("t1_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h04030201;
    step();
    chk("t1_en0", wr_en, 4'hF); chk("t1_addr0", wr_addr, 0); chk("t1_data0", wr_data, 32'h04030201);
    in_data = 32'h08070605;
    step();
    chk("t1_en1", wr_en, 4'hF); chk("t1_addr1", wr_addr, 1);
    chk("t1_done", frame_done, 1); chk("t1_pc", pixel_count, 8);
    in_valid = 1'b0;
    step();
    chk("t1_done_off", frame_done, 0); chk("t1_busy_off", busy, 0);
    step();

    // 1x6 frame: partial final word, valid held through DONE
    pulse_start(1, 6);
    in_valid = 1'b1; in_data = 32'hA3A2A1A0;
    step();
    chk("t2_pc0", pixel_count, 4);
    in_data = 32'hB3B2B1B0;
    step();
    chk("t2_en1", wr_en, 4'h3); chk("t2_pc1", pixel_count, 6); chk("t2_busy_done", busy, 1);
    in_data = 32'hC3C2C1C0;
    step();
    chk("t2_busy_low", busy, 0); chk("t2_no_consume", wr_en, 0); chk("t2_addr_hold", wr_addr, 1);
    step();
    chk("t2_idle_no_write", wr_en, 0);
    in_valid = 1'b0;

    // zero dimension start
    pulse_start(0, 5);
    chk("t3_dim_err", dim_err, 1); chk("t3_ready", in_ready, 0); chk("t3_busy", busy, 0);
    in_valid = 1'b1;
    step();
    chk("t3_no_write", wr_en, 0);
    in_valid = 1'b0;

    // gapped valid on 1x8, start ignored mid-frame
    pulse_start(1, 8);
    chk("t4_dim_clr", dim_err, 0);
    in_valid = 1'b1; in_data = 32'h11111111;
    step();
    chk("t4_en0", wr_en, 4'hF); chk("t4_addr0", wr_addr, 0);
    in_valid = 1'b0; rows = '0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_gap_en", wr_en, 0); chk("t4_gap_addr", wr_addr, 0); chk("t4_ign_start", dim_err, 0);
    step();
    in_valid = 1'b1; in_data = 32'h22222222;
    step();
    chk("t4_en1", wr_en, 4'hF); chk("t4_addr1", wr_addr, 1); chk("t4_done", frame_done, 1);
    in_valid = 1'b0;
    step();

    // 1x24 frame, six words into DEPTH=4
    pulse_start(1, 24);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 32'h50505050 + 32'(k);
      step();
      chk("t5_addr", wr_addr, RING ? (k % 4) : k);
      chk("t5_en", wr_en, (RING || k < 4) ? 4'hF : 4'h0);
      chk("t5_ovf", ovf, (!RING && k >= 4) ? 1 : 0);
    end
    chk("t5_pc", pixel_count, 24); chk("t5_done", frame_done, 1);
    in_valid = 1'b0;
    step();

    // reset mid-frame, then a clean frame
    pulse_start(4, 4);
    chk("t6_ovf_clr", ovf, 0);
    in_valid = 1'b1; in_data = 32'h99999999;
    step();
    chk("t6_en0", wr_en, 4'hF);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("t6_rst_en", wr_en, 0); chk("t6_rst_addr", wr_addr, 0); chk("t6_rst_data", wr_data, 0);
    chk("t6_rst_pc", pixel_count, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_done", frame_done, 0); chk("t6_rst_dim", dim_err, 0); chk("t6_rst_ovf", ovf, 0);
    rst = 1'b0;
    step();
    pulse_start(1, 4);
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    step();
    chk("t6_new_en", wr_en, 4'hF); chk("t6_new_addr", wr_addr, 0);
    chk("t6_new_pc", pixel_count, 4); chk("t6_new_done", frame_done, 1);
    in_valid = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
